// File: rtl/snake_body_tracker.sv
// Snake segment list: advances one cell per move tick, grows after an apple,
// and stops in DEAD on a wall or self collision.
module snake_body_tracker #(
    parameter int MAX_LEN  = 50,
    parameter int INIT_LEN = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_reset,
    input  logic                    start,
    input  logic                    move_tick,
    input  logic [1:0]              dir,
    input  logic                    goodColl,
    output logic [MAX_LEN-1:0][7:0] body,
    output logic [3:0]              x,
    output logic [3:0]              y,
    output logic [5:0]              length,
    output logic                    badColl,
    output logic                    running
);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    localparam logic [1:0] UP    = 2'b00;
    localparam logic [1:0] DOWN  = 2'b01;
    localparam logic [1:0] LEFT  = 2'b10;
    localparam logic [1:0] RIGHT = 2'b11;

    function automatic logic [MAX_LEN-1:0][7:0] init_body();
        logic [MAX_LEN-1:0][7:0] b;
        b = '0;
        for (int i = 0; i < INIT_LEN; i++) b[i] = {4'd4, 4'(7 - i)};
        return b;
    endfunction

    state_t                  state_q;
    logic [1:0]              cur_dir_q;
    logic [5:0]              len_q;
    logic [MAX_LEN-1:0][7:0] body_q;
    logic                    grow_pend_q;
    logic                    running_q;
    logic                    bad_q;

    logic [1:0]              dir_d;
    logic [MAX_LEN-1:0][7:0] body_d;
    logic [5:0]              len_d;
    logic                    grow;
    logic                    wall;
    logic                    hit;
    logic [3:0]              hx, hy, nx, ny;
    logic [7:0]              nh;

    always_comb begin
        // Up/down and left/right differ only in bit 0, so a reversal is cur_dir ^ 1.
        dir_d = cur_dir_q;
        if (state_q == RUN && dir != (cur_dir_q ^ 2'b01)) dir_d = dir;

        grow = grow_pend_q | goodColl;
        hx   = body_q[0][7:4];
        hy   = body_q[0][3:0];
        nx   = hx;
        ny   = hy;
        wall = 1'b0;
        case (dir_d)
            UP:      begin wall = (hy == 4'd0);  ny = hy - 4'd1; end
            DOWN:    begin wall = (hy == 4'd15); ny = hy + 4'd1; end
            LEFT:    begin wall = (hx == 4'd0);  nx = hx - 4'd1; end
            default: begin wall = (hx == 4'd15); nx = hx + 4'd1; end
        endcase
        nh = {nx, ny};

        // The tail cell is vacated this tick unless the snake grows.
        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (body_q[i] == nh &&
                (i < int'(len_q) - 1 || (grow && i < int'(len_q))))
                hit = 1'b1;
        end

        len_d  = (grow && len_q < 6'(MAX_LEN)) ? len_q + 6'd1 : len_q;
        body_d = {body_q[MAX_LEN-2:0], nh};
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i >= int'(len_d)) body_d[i] = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_dir_q   <= DOWN;
            len_q       <= 6'(INIT_LEN);
            body_q      <= init_body();
            grow_pend_q <= 1'b0;
            running_q   <= 1'b0;
            bad_q       <= 1'b0;
        end else if (s_reset) begin
            state_q     <= IDLE;
            cur_dir_q   <= DOWN;
            len_q       <= 6'(INIT_LEN);
            body_q      <= init_body();
            grow_pend_q <= 1'b0;
            running_q   <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    cur_dir_q <= dir_d;
                    if (move_tick) begin
                        if (wall || hit) begin
                            state_q   <= DEAD;
                            running_q <= 1'b0;
                            bad_q     <= 1'b1;
                        end else begin
                            body_q      <= body_d;
                            len_q       <= len_d;
                            grow_pend_q <= 1'b0;
                        end
                    end else if (goodColl) begin
                        grow_pend_q <= 1'b1;
                    end
                end
                DEAD: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign body    = body_q;
    assign x       = body_q[0][7:4];
    assign y       = body_q[0][3:0];
    assign length  = len_q;
    assign badColl = bad_q;
    assign running = running_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker: directed scenarios plus random play checked
// against a queue-based snake model.
module tb_snake_body_tracker;
    localparam int MAX_LEN  = 50;
    localparam int INIT_LEN = 3;

    logic clk = 1'b0, reset = 1'b0, s_reset = 1'b0, start = 1'b0;
    logic move_tick = 1'b0, goodColl = 1'b0;
    logic [1:0] dir = 2'b01;
    logic [MAX_LEN-1:0][7:0] body;
    logic [3:0] x, y;
    logic [5:0] length;
    logic badColl, running;

    snake_body_tracker #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
        .clk(clk), .reset(reset), .s_reset(s_reset), .start(start),
        .move_tick(move_tick), .dir(dir), .goodColl(goodColl),
        .body(body), .x(x), .y(y), .length(length),
        .badColl(badColl), .running(running)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: head is m_seg[0]; state 0 idle, 1 run, 2 dead.
    logic [7:0] m_seg[$];
    logic [1:0] m_dir;
    int         m_state;
    bit         m_pend;

    task automatic model_reset();
        m_seg.delete();
        for (int i = 0; i < INIT_LEN; i++) m_seg.push_back({4'd4, 4'(7 - i)});
        m_dir = 2'b01; m_state = 0; m_pend = 0;
    endtask

    task automatic model_step();
        int nx, ny, lim;
        bit g, coll;
        if (!reset || s_reset) begin model_reset(); return; end
        if (m_state == 0) begin
            if (start) m_state = 1;
        end else if (m_state == 1) begin
            if (!((dir == 0 && m_dir == 1) || (dir == 1 && m_dir == 0) ||
                  (dir == 2 && m_dir == 3) || (dir == 3 && m_dir == 2)))
                m_dir = dir;
            if (move_tick) begin
                nx = int'(m_seg[0][7:4]);
                ny = int'(m_seg[0][3:0]);
                case (m_dir)
                    2'b00: ny = ny - 1;
                    2'b01: ny = ny + 1;
                    2'b10: nx = nx - 1;
                    default: nx = nx + 1;
                endcase
                g = m_pend || goodColl;
                coll = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 15);
                lim = g ? m_seg.size() : m_seg.size() - 1;
                for (int i = 0; i < lim; i++)
                    if (!coll && m_seg[i] == {nx[3:0], ny[3:0]}) coll = 1;
                if (coll) m_state = 2;
                else begin
                    m_seg.push_front({nx[3:0], ny[3:0]});
                    if (!(g && m_seg.size() <= MAX_LEN)) void'(m_seg.pop_back());
                    m_pend = 0;
                end
            end else if (goodColl) begin
                m_pend = 1;
            end
        end
    endtask

    function automatic logic [MAX_LEN*8-1:0] exp_body();
        logic [MAX_LEN*8-1:0] e;
        e = '0;
        for (int i = 0; i < m_seg.size(); i++) e[i*8 +: 8] = m_seg[i];
        return e;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick(input logic [1:0] d, input logic g);
        dir = d; goodColl = g; move_tick = 1'b1;
        cycle();
        goodColl = 1'b0; move_tick = 1'b0;
    endtask

    task automatic pulse_sreset();
        s_reset = 1'b1; cycle(); s_reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        n_tests++; if (body[0] !== 8'h47) begin n_fail++; $display("FAIL reset_body0 got %h exp 47", body[0]); end
        n_tests++; if (body[1] !== 8'h46) begin n_fail++; $display("FAIL reset_body1 got %h exp 46", body[1]); end
        n_tests++; if (body[2] !== 8'h45) begin n_fail++; $display("FAIL reset_body2 got %h exp 45", body[2]); end
        n_tests++; if (body[MAX_LEN-1:3] !== '0) begin n_fail++; $display("FAIL reset_upper got %h exp 0", body[MAX_LEN-1:3]); end
        n_tests++; if (length !== 6'd3) begin n_fail++; $display("FAIL reset_len got %0d exp 3", length); end
        n_tests++; if (x !== 4'd4 || y !== 4'd7) begin n_fail++; $display("FAIL reset_xy got %0d,%0d exp 4,7", x, y); end
        n_tests++; if (running !== 1'b0 || badColl !== 1'b0) begin n_fail++; $display("FAIL reset_flags got run=%b bad=%b exp 0 0", running, badColl); end
    endtask

    task automatic test_move();
        pulse_start();
        tick(2'b01, 1'b0);
        n_tests++; if (body[2:0] !== {8'h46, 8'h47, 8'h48}) begin n_fail++; $display("FAIL move_body got %h exp 464748", body[2:0]); end
        n_tests++; if (body[3] !== 8'h00) begin n_fail++; $display("FAIL move_slot3 got %h exp 00", body[3]); end
        n_tests++; if (length !== 6'd3 || running !== 1'b1) begin n_fail++; $display("FAIL move_state got len=%0d run=%b exp 3 1", length, running); end
    endtask

    task automatic test_grow();
        tick(2'b11, 1'b1);
        n_tests++; if (body[0] !== 8'h58) begin n_fail++; $display("FAIL grow_head got %h exp 58", body[0]); end
        n_tests++; if (length !== 6'd4) begin n_fail++; $display("FAIL grow_len got %0d exp 4", length); end
        n_tests++; if (body[3] !== 8'h46) begin n_fail++; $display("FAIL grow_tail got %h exp 46", body[3]); end
        tick(2'b11, 1'b0);
        n_tests++; if (length !== 6'd4 || body[0] !== 8'h68) begin n_fail++; $display("FAIL grow_next got len=%0d head=%h exp 4 68", length, body[0]); end
    endtask

    task automatic test_reversal_wall();
        tick(2'b01, 1'b0);
        tick(2'b00, 1'b0);
        n_tests++; if (body[0] !== 8'h6A) begin n_fail++; $display("FAIL reversal_head got %h exp 6a", body[0]); end
        repeat (5) tick(2'b01, 1'b0);
        n_tests++; if (body[0] !== 8'h6F || running !== 1'b1) begin n_fail++; $display("FAIL wall_edge got head=%h run=%b exp 6f 1", body[0], running); end
        tick(2'b01, 1'b0);
        n_tests++; if (badColl !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL wall_flags got bad=%b run=%b exp 1 0", badColl, running); end
        n_tests++; if (body[3:0] !== {8'h6C, 8'h6D, 8'h6E, 8'h6F} || length !== 6'd4) begin n_fail++; $display("FAIL wall_frozen got %h len=%0d exp 6c6d6e6f 4", body[3:0], length); end
        tick(2'b10, 1'b1);
        pulse_start();
        n_tests++; if (body[0] !== 8'h6F || badColl !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL dead_hold got head=%h bad=%b run=%b exp 6f 1 0", body[0], badColl, running); end
    endtask

    task automatic test_sreset();
        pulse_sreset();
        n_tests++; if (body[2:0] !== {8'h45, 8'h46, 8'h47} || length !== 6'd3) begin n_fail++; $display("FAIL sreset_body got %h len=%0d exp 454647 3", body[2:0], length); end
        n_tests++; if (badColl !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL sreset_flags got bad=%b run=%b exp 0 0", badColl, running); end
        tick(2'b01, 1'b1);
        n_tests++; if (body[0] !== 8'h47 || length !== 6'd3 || running !== 1'b0) begin n_fail++; $display("FAIL idle_tick got head=%h len=%0d run=%b exp 47 3 0", body[0], length, running); end
    endtask

    task automatic test_tail_chase();
        pulse_start();
        tick(2'b01, 1'b1);
        tick(2'b11, 1'b0);
        tick(2'b00, 1'b0);
        tick(2'b10, 1'b0);
        n_tests++; if (body[0] !== 8'h47 || badColl !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL tail_enter got head=%h bad=%b run=%b exp 47 0 1", body[0], badColl, running); end
        n_tests++; if (length !== 6'd4) begin n_fail++; $display("FAIL tail_len got %0d exp 4", length); end
        pulse_sreset();
        pulse_start();
        tick(2'b01, 1'b1);
        tick(2'b01, 1'b1);
        tick(2'b11, 1'b0);
        tick(2'b00, 1'b0);
        tick(2'b10, 1'b0);
        n_tests++; if (badColl !== 1'b1 || body[0] !== 8'h58 || length !== 6'd5) begin n_fail++; $display("FAIL self_coll got bad=%b head=%h len=%0d exp 1 58 5", badColl, body[0], length); end
    endtask

    task automatic test_saturate();
        bit vdown;
        logic [1:0] d;
        pulse_sreset();
        pulse_start();
        vdown = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (vdown && m_seg[0][3:0] == 4'd15) begin d = 2'b11; vdown = 1'b0; end
            else if (!vdown && m_seg[0][3:0] == 4'd0) begin d = 2'b11; vdown = 1'b1; end
            else d = vdown ? 2'b01 : 2'b00;
            tick(d, 1'b1);
            n_tests++; if (length !== 6'(m_seg.size()) || badColl !== 1'b0) begin n_fail++; $display("FAIL sat_step%0d got len=%0d bad=%b exp %0d 0", k, length, badColl, m_seg.size()); end
        end
        n_tests++; if (length !== 6'd50) begin n_fail++; $display("FAIL sat_len got %0d exp 50", length); end
        n_tests++; if (body !== exp_body()) begin n_fail++; $display("FAIL sat_body got %h exp %h", body, exp_body()); end
    endtask

    task automatic test_async_reset();
        pulse_sreset();
        pulse_start();
        tick(2'b01, 1'b0);
        tick(2'b01, 1'b0);
        #2 reset = 1'b0;
        #1 model_reset();
        n_tests++; if (body[2:0] !== {8'h45, 8'h46, 8'h47} || length !== 6'd3 || running !== 1'b0) begin n_fail++; $display("FAIL async_reset got %h len=%0d run=%b exp 454647 3 0", body[2:0], length, running); end
        cycle();
        reset = 1'b1;
    endtask

    task automatic test_random();
        pulse_sreset();
        for (int k = 0; k < 1500; k++) begin
            s_reset   = ((m_state == 2) && ($urandom % 4 == 0)) || ($urandom % 300 == 0);
            start     = ($urandom % 8 == 0);
            move_tick = ($urandom % 3 == 0);
            dir       = 2'($urandom);
            goodColl  = ($urandom % 5 == 0);
            cycle();
            n_tests++;
            if (body !== exp_body() || length !== 6'(m_seg.size()) ||
                x !== m_seg[0][7:4] || y !== m_seg[0][3:0] ||
                running !== (m_state == 1) || badColl !== (m_state == 2)) begin
                n_fail++;
                $display("FAIL random_cyc%0d got len=%0d xy=%h run=%b bad=%b exp len=%0d xy=%h st=%0d",
                         k, length, {x, y}, running, badColl, m_seg.size(), m_seg[0], m_state);
            end
        end
        s_reset = 1'b0; start = 1'b0; move_tick = 1'b0; goodColl = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_move();
        test_grow();
        test_reversal_wall();
        test_sreset();
        test_tail_chase();
        test_saturate();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
